gf_mul_16_seq_ctrl: RTL and testbench

- Computes one GF(2^16) product using a single shared, fixed-latency GF(2^8) multiplier instead of five parallel instances.
- GF(2^16) is GF(2^8)[z]/(z^2 + z + IRRED_CST). The block time-multiplexes the multiplier and accumulates the result: a1 = x0y1 ^ x1y0 ^ x1y1, a0 = x0y0 ^ (x1y1 * IRRED_CST).
- Sits between GF(2^16) consumers and one gf_mul instance (REG_IN=1, REG_OUT=1). The GF(2^8) additions are XOR in local registers.

---
 rtl/gf_mul_16_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gf_mul_16_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mul_16_seq_ctrl.sv
// gf_mul_16_seq_ctrl
//   Computes one GF(2^16) product, with GF(2^16) = GF(2^8)[z]/(z^2 + z + IRRED_CST).
//   A single shared, fixed-latency GF(2^8) multiplier is time-multiplexed:
//     a1 = x0*y1 ^ x1*y0 ^ x1*y1
//     a0 = x0*y0 ^ (x1*y1)*IRRED_CST
//   Four partial products are issued back to back. The fifth product (x1*y1 by
//   the constant) is issued once x1*y1 has returned. GF(2^8) additions are XORs
//   into local accumulators.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             request, accepted only while o_busy = 0
//   i_x, i_y            operands {x1,x0} / {y1,y0}, sampled on accept
//   o_o                 result {a1,a0}, held until the next completed operation
//   o_done              one-cycle pulse when o_o is updated
//   o_busy              high whenever a start would be ignored
//   o_err               one-cycle pulse when a multiplier result times out
//   o_mul_start         issue strobe to the GF(2^8) multiplier
//   o_mul_a, o_mul_b    multiplier operands
//   i_mul_out           multiplier result
//   i_mul_done          multiplier result valid
module gf_mul_16_seq_ctrl #(
   parameter int         MUL_LAT   = 2,
   parameter logic [7:0] IRRED_CST = 8'h20,
   parameter int         TIMEOUT   = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   output logic [15:0] o_o,
   output logic        o_done,
   output logic        o_busy,
   output logic        o_err,
   output logic        o_mul_start,
   output logic [7:0]  o_mul_a,
   output logic [7:0]  o_mul_b,
   input  logic [7:0]  i_mul_out,
   input  logic        i_mul_done
);

   localparam int DCW = $clog2(MUL_LAT + 2);
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      DRAIN,
      IDLE,
      ISSUE,
      COLLECT,
      MUL_C,
      WAIT_C,
      FIN
   } state_t;

   state_t          state;
   state_t          next;
   logic [DCW-1:0]  dcnt;
   logic [1:0]      icnt;
   logic [2:0]      rcnt;
   logic [WDW-1:0]  wd;
   logic [15:0]     xs;
   logic [15:0]     ys;
   logic [7:0]      acc0;
   logic [7:0]      acc1;
   logic [7:0]      p11;
   logic [15:0]     res;
   logic            err;
   logic            abort;
   logic            collect;
   logic            wd_expired;

   // Partial products can already return while ISSUE is still running
   // (MUL_LAT < 4), so results are taken in both states.
   assign collect    = (state == ISSUE) || (state == COLLECT);
   assign wd_expired = !i_mul_done && (wd == WDW'(TIMEOUT - 1));

   always_comb begin
      next        = state;
      o_mul_start = 1'b0;
      o_mul_a     = 8'h00;
      o_mul_b     = 8'h00;
      abort       = 1'b0;
      case (state)
         DRAIN: begin
            if (dcnt == DCW'(MUL_LAT))
               next = IDLE;
         end
         IDLE: begin
            if (i_start)
               next = ISSUE;
         end
         ISSUE: begin
            // icnt[1] picks x1/x0, icnt[0] picks y1/y0: (x0,y0),(x0,y1),(x1,y0),(x1,y1)
            o_mul_start = 1'b1;
            o_mul_a     = icnt[1] ? xs[15:8] : xs[7:0];
            o_mul_b     = icnt[0] ? ys[15:8] : ys[7:0];
            if (icnt == 2'd3)
               next = COLLECT;
         end
         COLLECT: begin
            if (i_mul_done && (rcnt == 3'd3)) begin
               next = MUL_C;
            end else if (wd_expired) begin
               abort = 1'b1;
               next  = DRAIN;
            end
         end
         MUL_C: begin
            o_mul_start = 1'b1;
            o_mul_a     = p11;
            o_mul_b     = IRRED_CST;
            next        = WAIT_C;
         end
         WAIT_C: begin
            if (i_mul_done) begin
               next = FIN;
            end else if (wd_expired) begin
               abort = 1'b1;
               next  = DRAIN;
            end
         end
         FIN: begin
            next = IDLE;
         end
         default: begin
            next = DRAIN;
         end
      endcase
   end

   // Control state: FSM, counters, watchdog, result and error registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= DRAIN;
         dcnt  <= '0;
         icnt  <= '0;
         rcnt  <= '0;
         wd    <= '0;
         res   <= '0;
         err   <= 1'b0;
      end else begin
         state <= next;
         err   <= abort;
         // DRAIN length is counted from entry; the counter idles at zero elsewhere
         dcnt  <= (state == DRAIN) ? dcnt + 1'b1 : '0;
         if (state == IDLE) begin
            icnt <= '0;
            rcnt <= '0;
         end
         if (state == ISSUE)
            icnt <= icnt + 1'b1;
         if (collect && i_mul_done)
            rcnt <= rcnt + 1'b1;
         // Cycles since the last issue or received result; only compared
         // in states where a result is outstanding.
         wd <= (o_mul_start || i_mul_done) ? WDW'(1) : wd + 1'b1;
         if ((state == WAIT_C) && i_mul_done)
            res <= {acc1, acc0 ^ i_mul_out};
      end
   end

   // Operand capture and GF(2^8) accumulation (datapath, no reset)
   always_ff @(posedge i_clk) begin
      if ((state == IDLE) && i_start) begin
         xs <= i_x;
         ys <= i_y;
      end
      if (collect && i_mul_done) begin
         case (rcnt)
            3'd0: acc0 <= i_mul_out;
            3'd1: acc1 <= i_mul_out;
            3'd2: acc1 <= acc1 ^ i_mul_out;
            3'd3: begin
               acc1 <= acc1 ^ i_mul_out;
               p11  <= i_mul_out;
            end
            default: ;
         endcase
      end
   end

   assign o_o    = res;
   assign o_done = (state == FIN);
   assign o_busy = (state != IDLE);
   assign o_err  = err;

endmodule

// File: tb/tb_gf_mul_16_seq_ctrl.sv
// Directed testbench for gf_mul_16_seq_ctrl with a behavioural fixed-latency
// GF(2^8) multiplier (polynomial 0x11B). Instance A uses IRRED_CST=8'h20 and a
// multiplier model that can stall or inject a stray done; instance B uses
// IRRED_CST=8'h1B and shares the request inputs.
module tb_gf_mul_16_seq_ctrl;

   localparam int MUL_LAT = 2;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] x;
   logic [15:0] y;

   logic [15:0] o_a, o_b;
   logic        done_a, busy_a, err_a, ms_a;
   logic        done_b, busy_b, err_b, ms_b;
   logic [7:0]  ma_a, mb_a, mo_a, ma_b, mb_b, mo_b;
   logic        md_a, md_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] iss_q[$];
   int          iss_c[$];

   always #5 clk = ~clk;

   gf_mul_16_seq_ctrl #(.MUL_LAT(MUL_LAT), .IRRED_CST(8'h20), .TIMEOUT(TIMEOUT)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_x(x), .i_y(y),
      .o_o(o_a), .o_done(done_a), .o_busy(busy_a), .o_err(err_a),
      .o_mul_start(ms_a), .o_mul_a(ma_a), .o_mul_b(mb_a),
      .i_mul_out(mo_a), .i_mul_done(md_a)
   );

   gf_mul_16_seq_ctrl #(.MUL_LAT(MUL_LAT), .IRRED_CST(8'h1B), .TIMEOUT(TIMEOUT)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_x(x), .i_y(y),
      .o_o(o_b), .o_done(done_b), .o_busy(busy_b), .o_err(err_b),
      .o_mul_start(ms_b), .o_mul_a(ma_b), .o_mul_b(mb_b),
      .i_mul_out(mo_b), .i_mul_done(md_b)
   );

   function automatic logic [7:0] gf8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      end
      return p;
   endfunction

   // Multiplier model A: fixed latency, optional stall after two results, optional stray done
   logic [MUL_LAT:1] pv_a = '0;
   logic [7:0]       pd_a [1:MUL_LAT];
   int               mcnt = 0;
   logic             drop_en = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             inj = 1'b0;

   always @(posedge clk) begin
      pv_a[1] <= ms_a;
      pd_a[1] <= gf8(ma_a, mb_a);
      for (int k = 2; k <= MUL_LAT; k++) begin
         pv_a[k] <= pv_a[k-1];
         pd_a[k] <= pd_a[k-1];
      end
      if (cnt_clr) mcnt <= 0;
      else if (pv_a[MUL_LAT]) mcnt <= mcnt + 1;
   end

   assign md_a = (pv_a[MUL_LAT] && !(drop_en && (mcnt >= 2))) || inj;
   assign mo_a = inj ? 8'hFF : pd_a[MUL_LAT];

   // Multiplier model B: plain fixed latency
   logic [MUL_LAT:1] pv_b = '0;
   logic [7:0]       pd_b [1:MUL_LAT];

   always @(posedge clk) begin
      pv_b[1] <= ms_b;
      pd_b[1] <= gf8(ma_b, mb_b);
      for (int k = 2; k <= MUL_LAT; k++) begin
         pv_b[k] <= pv_b[k-1];
         pd_b[k] <= pd_b[k-1];
      end
   end

   assign md_b = pv_b[MUL_LAT];
   assign mo_b = pd_b[MUL_LAT];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Issues one request in the current cycle (cycle 0) and observes 40 cycles.
   task automatic do_op(input logic [15:0] xv, input logic [15:0] yv,
                        input int p1, input int p2, input int inj_c,
                        output int done_c, output int ndone,
                        output int nerr, output int err_c, output int busy_after);
      done_c = -1; ndone = 0; nerr = 0; err_c = -1; busy_after = -1;
      iss_q.delete();
      iss_c.delete();
      x = xv;
      y = yv;
      start = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) start = (c == p1) || (c == p2);
         inj = (c == inj_c);
         if ((done_c >= 0) && (c == done_c + 1)) busy_after = int'(busy_a);
         if (done_a) begin ndone++; done_c = c; end
         if (err_a) begin nerr++; err_c = c; end
         if (ms_a) begin iss_q.push_back({ma_a, mb_a}); iss_c.push_back(c); end
         step();
      end
      start = 1'b0;
      inj   = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int dc, nd, ne, ec, ba, w;
      logic [15:0] exp_iss [5];
      int          exp_cyc [5];
      logic [15:0] obs16;
      int          obsc;

      exp_iss = '{16'h0204, 16'h0205, 16'h0304, 16'h0305, 16'h0F20};
      exp_cyc = '{1, 2, 3, 4, 7};

      rst = 1'b1; start = 1'b0; x = '0; y = '0;
      step();
      step();
      chk("rst_o",      o_a, 16'h0000);
      chk("rst_done",   done_a, 1'b0);
      chk("rst_err",    err_a, 1'b0);
      chk("rst_mstart", ms_a, 1'b0);
      chk("rst_mab",    {ma_a, mb_a}, 16'h0000);
      chk("rst_busy",   busy_a, 1'b1);
      rst = 1'b0;
      w = 0;
      while (busy_a && (w < 20)) begin step(); w++; end
      chk("drain_len", w, MUL_LAT + 1);

      // Basic product, latency and release of busy
      do_op(16'h0001, 16'hABCD, -1, -1, -1, dc, nd, ne, ec, ba);
      chk("op1_o", o_a, 16'hABCD);
      chk("op1_done_cycle", dc, 2 * MUL_LAT + 6);
      chk("op1_ndone", nd, 1);
      chk("op1_busy_after", ba, 0);

      // z*z = z + IRRED_CST for both constants
      do_op(16'h0100, 16'h0100, -1, -1, -1, dc, nd, ne, ec, ba);
      chk("op2_o_a", o_a, 16'h0120);
      chk("op2_o_b", o_b, 16'h011B);
      chk("op2_b_idle", {busy_b, done_b, err_b}, 3'b000);

      // Starts while busy are dropped
      do_op(16'h0100, 16'h0001, 3, 9, -1, dc, nd, ne, ec, ba);
      chk("op3_o", o_a, 16'h0100);
      chk("op3_ndone", nd, 1);
      chk("op3_done_cycle", dc, 10);

      // Issue order and operands
      do_op(16'h0302, 16'h0504, -1, -1, -1, dc, nd, ne, ec, ba);
      chk("op4_o", o_a, 16'h09F3);
      chk("op4_nissue", iss_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         obs16 = (i < iss_q.size()) ? iss_q[i] : 16'hxxxx;
         obsc  = (i < iss_c.size()) ? iss_c[i] : -1;
         chk($sformatf("op4_issue%0d", i), obs16, exp_iss[i]);
         chk($sformatf("op4_issue%0d_cycle", i), obsc, exp_cyc[i]);
      end

      // Multiplier stalls after two results; stray done injected during DRAIN
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      drop_en = 1'b1;
      do_op(16'h0302, 16'h0504, -1, -1, 21, dc, nd, ne, ec, ba);
      drop_en = 1'b0;
      chk("to_err_cycle", ec, 4 + TIMEOUT);
      chk("to_nerr", ne, 1);
      chk("to_ndone", nd, 0);
      chk("to_o_kept", o_a, 16'h09F3);

      do_op(16'h0001, 16'hABCD, -1, -1, -1, dc, nd, ne, ec, ba);
      chk("after_to_o", o_a, 16'hABCD);
      chk("after_to_done_cycle", dc, 10);

      // Reset while collecting
      x = 16'h0302; y = 16'h0504; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      chk("pre_rst_busy", busy_a, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_o", o_a, 16'h0000);
      chk("mid_rst_flags", {done_a, err_a, ms_a}, 3'b000);
      chk("mid_rst_mab", {ma_a, mb_a}, 16'h0000);
      chk("mid_rst_busy", busy_a, 1'b1);
      w = 0;
      while (busy_a && (w < 20)) begin step(); w++; end
      chk("mid_rst_drain_len", w, MUL_LAT + 1);

      do_op(16'h0100, 16'h0100, -1, -1, -1, dc, nd, ne, ec, ba);
      chk("after_rst_o", o_a, 16'h0120);
      chk("after_rst_done_cycle", dc, 10);
      chk("after_rst_nerr", ne, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
